// File: rtl/router_pkt_register.sv
// Packet datapath register for the 1x3 router: header/payload capture, full-FIFO byte replay
// and XOR parity check. Define ROUTER_PARITY_CHECK_EN to build the parity compare (err).
module router_pkt_register #(
    parameter int         WIDTH        = 8,
    parameter logic [1:0] BLOCKED_ADDR = 2'b11
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             lfd_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] header_q, header_d;
    logic [WIDTH-1:0] full_byte_q, full_byte_d;
    logic             pd_q, pd_d;
    logic             low_q, low_d;

    always_comb begin
        header_d = header_q;
        if (detect_add && pkt_valid && data_in[1:0] != BLOCKED_ADDR)
            header_d = data_in;

        // A byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
        dout_d      = dout_q;
        full_byte_d = full_byte_q;
        if (lfd_state)
            dout_d = header_q;
        else if (ld_state && !fifo_full)
            dout_d = data_in;
        else if (ld_state)
            full_byte_d = data_in;
        else if (laf_state)
            dout_d = full_byte_q;

        low_d = low_q;
        if (rst_int_reg)
            low_d = 1'b0;
        else if (ld_state && !pkt_valid)
            low_d = 1'b1;

        pd_d = pd_q;
        if (detect_add)
            pd_d = 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && low_q && !pd_q))
            pd_d = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout_q      <= '0;
            header_q    <= '0;
            full_byte_q <= '0;
            pd_q        <= 1'b0;
            low_q       <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            header_q    <= header_d;
            full_byte_q <= full_byte_d;
            pd_q        <= pd_d;
            low_q       <= low_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = pd_q;
    assign low_pkt_valid = low_q;

`ifdef ROUTER_PARITY_CHECK_EN
    logic [WIDTH-1:0] int_parity_q, int_parity_d;
    logic [WIDTH-1:0] pkt_parity_q, pkt_parity_d;
    logic             err_q, err_d;
    logic             pd_seen_q;

    always_comb begin
        int_parity_d = int_parity_q;
        if (detect_add)
            int_parity_d = '0;
        else if (lfd_state)
            int_parity_d = int_parity_q ^ header_q;
        else if (ld_state && pkt_valid && !full_state)
            int_parity_d = int_parity_q ^ data_in;

        pkt_parity_d = pkt_parity_q;
        if (detect_add)
            pkt_parity_d = '0;
        else if (ld_state && !pkt_valid)
            pkt_parity_d = data_in;

        // Compare once, on the cycle after parity_done rises; sticky until the next header.
        err_d = err_q;
        if (detect_add)
            err_d = 1'b0;
        else if (pd_q && !pd_seen_q)
            err_d = (int_parity_q != pkt_parity_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity_q <= '0;
            pkt_parity_q <= '0;
            err_q        <= 1'b0;
            pd_seen_q    <= 1'b0;
        end else begin
            int_parity_q <= int_parity_d;
            pkt_parity_q <= pkt_parity_d;
            err_q        <= err_d;
            pd_seen_q    <= pd_q;
        end
    end

    assign err = err_q;
`else
    logic unused_full_state;
    assign unused_full_state = full_state;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_register.sv
// Directed bench for router_pkt_register; FSM state inputs are driven directly per cycle.
// Expected err values follow ROUTER_PARITY_CHECK_EN.
module tb_router_pkt_register;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, fifo_full, detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg;
    logic [7:0] data_in;
    logic [7:0] dout;
    logic       parity_done, low_pkt_valid, err;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef ROUTER_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    router_pkt_register #(.WIDTH(8), .BLOCKED_ADDR(2'b11)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
        .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // One clock: apply {detect,lfd,ld,laf,full_state}, pkt_valid, fifo_full, rst_int_reg, data.
    task automatic cyc(input logic [4:0] st, input logic pv, input logic ff, input logic ri,
                       input logic [7:0] d);
        {detect_add, lfd_state, ld_state, laf_state, full_state} = st;
        pkt_valid = pv; fifo_full = ff; rst_int_reg = ri; data_in = d;
        @(posedge clock); #1;
    endtask

    localparam logic [4:0] S_DA = 5'b10000, S_LFD = 5'b01000, S_LD = 5'b00100,
                           S_LAF = 5'b00010, S_FUL = 5'b00001, S_IDL = 5'b00000;

    task automatic header_lfd(input logic [7:0] h);
        cyc(S_DA, 1, 0, 0, h);
        cyc(S_LFD, 1, 0, 0, 8'h00);
    endtask

    initial begin
        resetn = 1'b0;
        cyc(S_IDL, 0, 0, 0, 8'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_pd", {7'b0, parity_done}, 8'h00);
        chk("rst_low", {7'b0, low_pkt_valid}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        #2 resetn = 1'b1;

        // T2 good packet
        header_lfd(8'h0D);
        chk("t2_hdr", dout, 8'h0D);
        cyc(S_LD, 1, 0, 0, 8'h11); chk("t2_d1", dout, 8'h11);
        cyc(S_LD, 1, 0, 0, 8'h22); chk("t2_d2", dout, 8'h22);
        cyc(S_LD, 1, 0, 0, 8'h33); chk("t2_d3", dout, 8'h33);
        chk("t2_pd_early", {7'b0, parity_done}, 8'h00);
        cyc(S_LD, 0, 0, 0, 8'h0D); chk("t2_par", dout, 8'h0D);
        chk("t2_pd", {7'b0, parity_done}, 8'h01);
        chk("t2_low", {7'b0, low_pkt_valid}, 8'h01);
        cyc(S_IDL, 0, 0, 0, 8'h00); chk("t2_err", {7'b0, err}, 8'h00);
        cyc(S_IDL, 0, 0, 1, 8'h00); chk("t2_lowclr", {7'b0, low_pkt_valid}, 8'h00);

        // T3 bad parity
        header_lfd(8'h0D);
        chk("t3_pd_clr", {7'b0, parity_done}, 8'h00);
        cyc(S_LD, 1, 0, 0, 8'h11);
        cyc(S_LD, 1, 0, 0, 8'h22);
        cyc(S_LD, 1, 0, 0, 8'h33);
        cyc(S_LD, 0, 0, 0, 8'h0E);
        chk("t3_pd", {7'b0, parity_done}, 8'h01);
        chk("t3_err_early", {7'b0, err}, 8'h00);
        cyc(S_IDL, 0, 0, 0, 8'h00); chk("t3_err", {7'b0, err}, {7'b0, PAR_EN});
        cyc(S_IDL, 0, 0, 0, 8'h00); chk("t3_err_sticky", {7'b0, err}, {7'b0, PAR_EN});
        cyc(S_DA, 1, 0, 1, 8'h0D);
        chk("t3_err_clr", {7'b0, err}, 8'h00);
        chk("t3_pd_clr2", {7'b0, parity_done}, 8'h00);

        // T4 full stall mid-payload
        cyc(S_LFD, 1, 0, 0, 8'h00); chk("t4_hdr", dout, 8'h0D);
        cyc(S_LD, 1, 0, 0, 8'h11);
        cyc(S_LD, 1, 1, 0, 8'h22); chk("t4_hold", dout, 8'h11);
        cyc(S_FUL, 1, 1, 0, 8'h33); chk("t4_hold2", dout, 8'h11);
        cyc(S_LAF, 1, 0, 0, 8'h33); chk("t4_replay", dout, 8'h22);
        chk("t4_pd_laf", {7'b0, parity_done}, 8'h00);
        cyc(S_LD, 1, 0, 0, 8'h33); chk("t4_d3", dout, 8'h33);
        cyc(S_LD, 0, 0, 0, 8'h0D); chk("t4_pd", {7'b0, parity_done}, 8'h01);
        cyc(S_IDL, 0, 0, 0, 8'h00); chk("t4_err", {7'b0, err}, 8'h00);
        cyc(S_IDL, 0, 0, 1, 8'h00);

        // T5 full on the parity byte
        header_lfd(8'h0D);
        cyc(S_LD, 1, 0, 0, 8'h11);
        cyc(S_LD, 1, 0, 0, 8'h22);
        cyc(S_LD, 1, 0, 0, 8'h33);
        cyc(S_LD, 0, 1, 0, 8'h0D);
        chk("t5_low", {7'b0, low_pkt_valid}, 8'h01);
        chk("t5_pd0", {7'b0, parity_done}, 8'h00);
        chk("t5_hold", dout, 8'h33);
        cyc(S_FUL, 0, 1, 0, 8'h00); chk("t5_pd_full", {7'b0, parity_done}, 8'h00);
        cyc(S_LAF, 0, 0, 0, 8'h00);
        chk("t5_pd", {7'b0, parity_done}, 8'h01);
        chk("t5_replay", dout, 8'h0D);
        cyc(S_IDL, 0, 0, 0, 8'h00); chk("t5_err", {7'b0, err}, 8'h00);
        cyc(S_IDL, 0, 0, 1, 8'h00);

        // T6 blocked address leaves the previous header in place
        cyc(S_DA, 1, 0, 0, 8'h0F);
        cyc(S_LD, 1, 0, 0, 8'h55); chk("t6_ld", dout, 8'h55);
        cyc(S_LFD, 1, 0, 0, 8'h00); chk("t6_blocked", dout, 8'h0D);
        header_lfd(8'h0E); chk("t6_accept", dout, 8'h0E);
        cyc(S_IDL, 0, 0, 1, 8'h00);

        // T1 async reset mid-packet
        header_lfd(8'hA5); chk("t1_hdr", dout, 8'hA5);
        cyc(S_LD, 0, 1, 0, 8'hA5);
        cyc(S_LAF, 0, 0, 0, 8'h00);
        chk("t1_pre_pd", {7'b0, parity_done}, 8'h01);
        chk("t1_pre_low", {7'b0, low_pkt_valid}, 8'h01);
        #2 resetn = 1'b0;
        #1;
        chk("t1_dout", dout, 8'h00);
        chk("t1_pd", {7'b0, parity_done}, 8'h00);
        chk("t1_low", {7'b0, low_pkt_valid}, 8'h00);
        chk("t1_err", {7'b0, err}, 8'h00);
        cyc(S_LFD, 1, 0, 0, 8'h00);
        chk("t1_hold_rst", dout, 8'h00);
        resetn = 1'b1;
        cyc(S_LFD, 1, 0, 0, 8'h00);
        chk("t1_hdr_cleared", dout, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
